// File: rtl/sdram_uart_dump.sv
// Streams WORD_COUNT 16-bit words from the SDRAM read FIFO out over UART as one framed dump:
// A5 5A, word count, data bytes hi/lo, then an 8-bit sum of the data bytes.
module sdram_uart_dump #(
  parameter logic [31:0] CLK_FREQ    = 32'd50_000_000,
  parameter logic [31:0] UART_BAUD   = 32'd115200,
  parameter logic [31:0] BYTE_PERIOD = (CLK_FREQ / UART_BAUD) * 11,
  parameter logic [15:0] WORD_COUNT  = 16'd512
) (
  input  logic        clk_50m,
  input  logic        reset,
  input  logic        start,
  input  logic        sdram_init_done,
  output logic        rd_en,
  input  logic [15:0] rd_data,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_enable,
  output logic        busy,
  output logic        done,
  output logic [7:0]  checksum
);

  typedef enum logic [2:0] {
    IDLE, HDR, FETCH, LATCH, SEND_HI, SEND_LO, CKSUM, DONE
  } state_t;

  localparam logic [31:0] GAP_LOAD = BYTE_PERIOD - 32'd1;

  state_t      state;
  logic [31:0] gap_cnt;
  logic [1:0]  hdr_idx;
  logic [15:0] words_left;
  logic [15:0] word_reg;
  logic        cksum_sent;
  logic        gap_done;

  assign gap_done = (gap_cnt == 32'd0);

  always_ff @(posedge clk_50m) begin
    if (reset) begin
      state          <= IDLE;
      rd_en          <= 1'b0;
      uart_tx_data   <= 8'h00;
      uart_tx_enable <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      checksum       <= 8'h00;
      gap_cnt        <= 32'd0;
      hdr_idx        <= 2'd0;
      words_left     <= 16'd0;
      word_reg       <= 16'd0;
      cksum_sent     <= 1'b0;
    end else begin
      rd_en          <= 1'b0;
      uart_tx_enable <= 1'b0;
      done           <= 1'b0;
      // The gap counter runs freely through FETCH/LATCH so word boundaries add no delay.
      if (!gap_done) gap_cnt <= gap_cnt - 32'd1;

      case (state)
        IDLE: begin
          if (start && sdram_init_done) begin
            state          <= HDR;
            busy           <= 1'b1;
            checksum       <= 8'h00;
            uart_tx_data   <= 8'hA5;
            uart_tx_enable <= 1'b1;
            gap_cnt        <= GAP_LOAD;
            hdr_idx        <= 2'd1;
            words_left     <= WORD_COUNT;
            cksum_sent     <= 1'b0;
          end
        end

        HDR: begin
          if (gap_done) begin
            uart_tx_enable <= 1'b1;
            gap_cnt        <= GAP_LOAD;
            hdr_idx        <= hdr_idx + 2'd1;
            case (hdr_idx)
              2'd1:    uart_tx_data <= 8'h5A;
              2'd2:    uart_tx_data <= WORD_COUNT[15:8];
              default: uart_tx_data <= WORD_COUNT[7:0];
            endcase
            if (hdr_idx == 2'd3) state <= FETCH;
          end
        end

        FETCH: begin
          rd_en <= 1'b1;
          state <= LATCH;
        end

        // The FIFO presents the word one cycle after the pop, so wait out the rd_en cycle first.
        LATCH: begin
          if (!rd_en) begin
            word_reg <= rd_data;
            state    <= SEND_HI;
          end
        end

        SEND_HI: begin
          if (gap_done) begin
            uart_tx_data   <= word_reg[15:8];
            uart_tx_enable <= 1'b1;
            gap_cnt        <= GAP_LOAD;
            checksum       <= checksum + word_reg[15:8];
            state          <= SEND_LO;
          end
        end

        SEND_LO: begin
          if (gap_done) begin
            uart_tx_data   <= word_reg[7:0];
            uart_tx_enable <= 1'b1;
            gap_cnt        <= GAP_LOAD;
            checksum       <= checksum + word_reg[7:0];
            words_left     <= words_left - 16'd1;
            state          <= (words_left == 16'd1) ? CKSUM : FETCH;
          end
        end

        // First expiry sends the checksum byte, second expiry closes the frame.
        CKSUM: begin
          if (gap_done) begin
            if (!cksum_sent) begin
              uart_tx_data   <= checksum;
              uart_tx_enable <= 1'b1;
              gap_cnt        <= GAP_LOAD;
              cksum_sent     <= 1'b1;
            end else begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_uart_dump.sv
// Scoreboard bench for sdram_uart_dump: three instances with different word counts and byte periods,
// expected frames pushed at start time and popped by a monitor that also checks pacing and rd_en timing.
module tb_sdram_uart_dump;

  localparam int NI = 3;

  function automatic int wc_of(input int g);
    case (g)
      0:       return 2;
      1:       return 1;
      default: return 512;
    endcase
  endfunction

  function automatic int bp_of(input int g);
    case (g)
      0:       return 8;
      1:       return 5;
      default: return 4;
    endcase
  endfunction

  logic          clk_50m = 1'b0;
  logic          reset = 1'b1;
  logic          sdram_init_done = 1'b0;
  logic [NI-1:0] start = '0;
  logic [NI-1:0] rd_en_w;
  logic [NI-1:0] tx_en_w;
  logic [NI-1:0] busy_w;
  logic [NI-1:0] done_w;
  logic [15:0]   rd_data_w [NI];
  logic [7:0]    tx_data_w [NI];
  logic [7:0]    cksum_w   [NI];

  always #5 clk_50m = ~clk_50m;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sdram_uart_dump #(
      .BYTE_PERIOD(32'(bp_of(g))),
      .WORD_COUNT (16'(wc_of(g)))
    ) dut (
      .clk_50m        (clk_50m),
      .reset          (reset),
      .start          (start[g]),
      .sdram_init_done(sdram_init_done),
      .rd_en          (rd_en_w[g]),
      .rd_data        (rd_data_w[g]),
      .uart_tx_data   (tx_data_w[g]),
      .uart_tx_enable (tx_en_w[g]),
      .busy           (busy_w[g]),
      .done           (done_w[g]),
      .checksum       (cksum_w[g])
    );
  end

  // Stimulus-owned scoreboard state
  logic [7:0]  exp_mem  [NI][2048];
  logic [15:0] fifo_mem [NI][1024];
  int          exp_wr   [NI];
  int          fifo_wr  [NI];
  int          exp_first[NI];
  logic [7:0]  exp_sum  [NI];
  logic [15:0] stage_words [512];

  // Monitor-owned state
  int         exp_rd     [NI];
  int         pidx       [NI];
  int         last_pulse [NI];
  int         rd_expect  [NI];
  int         done_expect[NI];
  int         rd_cnt     [NI];
  logic [7:0] prev_data  [NI];
  int         checks = 0;
  int         errors = 0;

  int   fifo_rd[NI];
  int   cyc = 0;
  logic reset_q = 1'b0;

  always @(posedge clk_50m) begin
    cyc     <= cyc + 1;
    reset_q <= reset;
  end

  // FIFO model: a pop seen at an edge presents the next word after that edge.
  always @(posedge clk_50m) begin
    for (int g = 0; g < NI; g++) begin
      if (reset) begin
        fifo_rd[g] = fifo_wr[g];
      end else if (rd_en_w[g]) begin
        if (fifo_rd[g] == fifo_wr[g]) begin
          rd_data_w[g] <= 16'hDEAD;
        end else begin
          rd_data_w[g] <= fifo_mem[g][fifo_rd[g] % 1024];
          fifo_rd[g] = fifo_rd[g] + 1;
        end
      end
    end
  end

  task automatic checkOutput(input int g, input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s inst%0d at cycle %0d: got %0h, expected %0h", name, g, cyc, act, exp);
    end
  endtask

  always @(negedge clk_50m) begin
    for (int g = 0; g < NI; g++) begin
      int p;
      int w;
      w = wc_of(g);
      if (reset_q) begin
        checkOutput(g, "rst_rd_en", rd_en_w[g], 0);
        checkOutput(g, "rst_tx_enable", tx_en_w[g], 0);
        checkOutput(g, "rst_tx_data", tx_data_w[g], 0);
        checkOutput(g, "rst_busy", busy_w[g], 0);
        checkOutput(g, "rst_done", done_w[g], 0);
        checkOutput(g, "rst_checksum", cksum_w[g], 0);
        pidx[g]        = 0;
        rd_expect[g]   = -1;
        done_expect[g] = -1;
        rd_cnt[g]      = 0;
        exp_rd[g]      = exp_wr[g];
        prev_data[g]   = 8'h00;
      end else begin
        if (!tx_en_w[g] && tx_data_w[g] !== prev_data[g])
          checkOutput(g, "data_hold", tx_data_w[g], prev_data[g]);
        prev_data[g] = tx_data_w[g];
        if (!tx_en_w[g] && pidx[g] == 0 && busy_w[g] !== 1'b0)
          checkOutput(g, "busy_idle", busy_w[g], 0);

        if (tx_en_w[g]) begin
          if (exp_rd[g] == exp_wr[g]) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_byte inst%0d at cycle %0d: got %0h, expected no byte", g, cyc, tx_data_w[g]);
          end else begin
            checkOutput(g, "byte", tx_data_w[g], exp_mem[g][exp_rd[g] % 2048]);
            exp_rd[g]++;
          end
          if (pidx[g] == 0) checkOutput(g, "first_latency", cyc, exp_first[g]);
          else              checkOutput(g, "byte_spacing", cyc - last_pulse[g], bp_of(g));
          checkOutput(g, "busy_in_frame", busy_w[g], 1);
          p = pidx[g];
          if (p == 3 || (p % 2 == 1 && p >= 5 && p <= 2*w + 1)) rd_expect[g] = cyc + 1;
          if (p == 2*w + 4) done_expect[g] = cyc + bp_of(g);
          last_pulse[g] = cyc;
          pidx[g]++;
        end

        if (rd_en_w[g] || cyc == rd_expect[g]) begin
          checkOutput(g, "rd_en_timing", rd_en_w[g], cyc == rd_expect[g]);
          if (rd_en_w[g]) rd_cnt[g]++;
        end

        if (done_w[g] || cyc == done_expect[g]) begin
          checkOutput(g, "done_timing", done_w[g], cyc == done_expect[g]);
          if (done_w[g]) begin
            checkOutput(g, "busy_at_done", busy_w[g], 0);
            checkOutput(g, "checksum", cksum_w[g], exp_sum[g]);
            checkOutput(g, "rd_en_count", rd_cnt[g], w);
            checkOutput(g, "frame_bytes", pidx[g], 2*w + 5);
          end
          pidx[g]        = 0;
          rd_cnt[g]      = 0;
          done_expect[g] = -1;
        end
      end
    end
  end

  task automatic pushExp(input int g, input logic [7:0] b);
    exp_mem[g][exp_wr[g] % 2048] = b;
    exp_wr[g] = exp_wr[g] + 1;
  endtask

  // Loads the FIFO with stage_words, queues the expected frame and pulses start.
  task automatic applyStimulus(input int g, input int n);
    logic [15:0] n16;
    logic [15:0] wd;
    logic [7:0]  s;
    n16 = 16'(n);
    s   = 8'h00;
    for (int i = 0; i < n; i++) begin
      fifo_mem[g][fifo_wr[g] % 1024] = stage_words[i];
      fifo_wr[g] = fifo_wr[g] + 1;
    end
    pushExp(g, 8'hA5);
    pushExp(g, 8'h5A);
    pushExp(g, n16[15:8]);
    pushExp(g, n16[7:0]);
    for (int i = 0; i < n; i++) begin
      wd = stage_words[i];
      pushExp(g, wd[15:8]);
      pushExp(g, wd[7:0]);
      s = s + wd[15:8] + wd[7:0];
    end
    pushExp(g, s);
    exp_sum[g]   = s;
    exp_first[g] = cyc + 1;
    start[g] = 1'b1;
    @(posedge clk_50m);
    #1 start[g] = 1'b0;
  endtask

  task automatic pokeStart(input int g);
    start[g] = 1'b1;
    @(posedge clk_50m);
    #1 start[g] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_50m);
    #1;
  endtask

  task automatic fillRandom(input int n);
    for (int i = 0; i < n; i++) stage_words[i] = 16'($urandom);
  endtask

  // Waits for done; optionally holds start high across the DONE-cycle edge.
  task automatic waitDone(input int g, input int limit, input bit poke_in_done);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk_50m);
      if (done_w[g]) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      $display("[TB] FAIL frame_timeout inst%0d: got no done within %0d cycles, expected done", g, limit);
      $fatal(1, "[TB] frame timeout");
    end
    if (poke_in_done) start[g] = 1'b1;
    @(posedge clk_50m);
    #1 start[g] = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    sdram_init_done = 1'b1;
    repeat (3) @(posedge clk_50m);
    #1 reset = 1'b0;
    idle(2);

    $display("[TB] directed two-word frame");
    stage_words[0] = 16'h1234;
    stage_words[1] = 16'hABCD;
    applyStimulus(0, 2);
    waitDone(0, 200, 1'b0);

    $display("[TB] start while SDRAM not initialised");
    sdram_init_done = 1'b0;
    idle(3);
    pokeStart(0);
    idle(40);
    sdram_init_done = 1'b1;
    fillRandom(2);
    applyStimulus(0, 2);
    waitDone(0, 200, 1'b0);

    $display("[TB] starts during busy and in the done cycle");
    fillRandom(2);
    applyStimulus(0, 2);
    idle(5);
    pokeStart(0);
    idle(20);
    pokeStart(0);
    waitDone(0, 200, 1'b1);
    fillRandom(2);
    applyStimulus(0, 2);
    waitDone(0, 200, 1'b0);

    $display("[TB] reset during a word gap");
    fillRandom(2);
    applyStimulus(0, 2);
    for (int i = 0; i < 200; i++) begin
      if (pidx[0] >= 5) break;
      idle(1);
    end
    idle(2);
    reset = 1'b1;
    @(posedge clk_50m);
    #1 reset = 1'b0;
    idle(30);
    fillRandom(2);
    applyStimulus(0, 2);
    waitDone(0, 200, 1'b0);

    $display("[TB] single-word frames");
    stage_words[0] = 16'hFFFF;
    applyStimulus(1, 1);
    waitDone(1, 100, 1'b0);
    fillRandom(1);
    applyStimulus(1, 1);
    waitDone(1, 100, 1'b0);

    $display("[TB] 512-word frame");
    fillRandom(512);
    applyStimulus(2, 512);
    waitDone(2, 6000, 1'b0);

    $display("[TB] random back-to-back frames");
    for (int k = 0; k < 6; k++) begin
      fillRandom(2);
      applyStimulus(0, 2);
      if ($urandom_range(0, 1) == 1) begin
        idle($urandom_range(1, 50));
        pokeStart(0);
      end
      waitDone(0, 200, 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 5));
    end

    idle(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
